// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: arbitrates load-use stalls, mul/div EX occupancy and branch flushes
// for the 5-stage pipeline, with a multi-cycle timeout and a saturating stall counter.
module pipeline_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int MC_TIMEOUT        = 32,
    parameter int CNT_W             = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Hazard_Req,
    input  logic             Branch_Taken,
    input  logic             MC_Start,
    input  logic             MC_Done,
    input  logic             Clr_Stats,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Hold_IDEX,
    output logic             Bubble_IDEX,
    output logic             Bubble_EXMEM,
    output logic             Flush_IFID,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Stall_Count,
    output logic             Timeout_Err
);
    localparam int LF   = LOAD_STALL_CYCLES > FLUSH_CYCLES ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int MAXC = LF > MC_TIMEOUT ? LF : MC_TIMEOUT;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {RUN, LOAD_STALL, MC_WAIT, FLUSH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          to_hit, s_pc, s_ifid, h_idex, b_idex, b_exmem, f_ifid;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        to_hit   = 1'b0;
        s_pc     = 1'b0;
        s_ifid   = 1'b0;
        h_idex   = 1'b0;
        b_idex   = 1'b0;
        b_exmem  = 1'b0;
        f_ifid   = 1'b0;
        // a completing mul/div hands the cycle back to normal arbitration
        if (state == RUN || (state == MC_WAIT && MC_Done)) begin
            if (MC_Start) begin
                {s_pc, s_ifid, h_idex, b_exmem} = 4'hf;
                state_nx = MC_WAIT;
                cnt_nx   = CW'(1);
            end else if (Hazard_Req) begin
                {s_pc, s_ifid, b_idex} = 3'h7;
                state_nx = LOAD_STALL_CYCLES > 1 ? LOAD_STALL : RUN;
                cnt_nx   = CW'(LOAD_STALL_CYCLES - 1);
            end else if (Branch_Taken) begin
                f_ifid   = 1'b1;
                state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
                cnt_nx   = CW'(FLUSH_CYCLES - 1);
            end else begin
                state_nx = RUN;
            end
        end else if (state == LOAD_STALL) begin
            {s_pc, s_ifid, b_idex} = 3'h7;
            cnt_nx   = cnt - CW'(1);
            state_nx = cnt == CW'(1) ? RUN : LOAD_STALL;
        end else if (state == MC_WAIT) begin
            {s_pc, s_ifid, h_idex, b_exmem} = 4'hf;
            cnt_nx   = cnt + CW'(1);
            to_hit   = cnt == CW'(MC_TIMEOUT);
            state_nx = to_hit ? RUN : MC_WAIT;
        end else begin
            f_ifid   = 1'b1;
            cnt_nx   = cnt - CW'(1);
            state_nx = cnt == CW'(1) ? RUN : FLUSH;
        end
    end

    // request-driven Mealy outputs must also drop while reset is held
    assign Stall_PC     = Reset_n & s_pc;
    assign Stall_IFID   = Reset_n & s_ifid;
    assign Hold_IDEX    = Reset_n & h_idex;
    assign Bubble_IDEX  = Reset_n & b_idex;
    assign Bubble_EXMEM = Reset_n & b_exmem;
    assign Flush_IFID   = Reset_n & f_ifid;
    assign State        = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= RUN;
            cnt         <= '0;
            Stall_Count <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (Clr_Stats)
                Stall_Count <= '0;
            else if (s_pc && !(&Stall_Count))
                Stall_Count <= Stall_Count + CNT_W'(1);
            if (Clr_Stats)
                Timeout_Err <= 1'b0;
            else if (to_hit)
                Timeout_Err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: two parameterisations driven by shared directed vectors,
// checked every cycle against a per-instance behavioural model plus literal pins.
module tb_pipeline_stall_ctrl;
    logic Clk = 1'b0, Reset_n, Hazard_Req, Branch_Taken, MC_Start, MC_Done, Clr_Stats;
    always #5 Clk = ~Clk;

    logic [5:0]  ctl [2];
    logic [1:0]  st [2];
    logic        te [2];
    logic [15:0] sc0;
    logic [1:0]  sc1;
    int          sc [2];

    pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .MC_TIMEOUT(32), .CNT_W(16)) d0 (
        .Clk(Clk), .Reset_n(Reset_n), .Hazard_Req(Hazard_Req), .Branch_Taken(Branch_Taken),
        .MC_Start(MC_Start), .MC_Done(MC_Done), .Clr_Stats(Clr_Stats),
        .Stall_PC(ctl[0][5]), .Stall_IFID(ctl[0][4]), .Hold_IDEX(ctl[0][3]), .Bubble_IDEX(ctl[0][2]),
        .Bubble_EXMEM(ctl[0][1]), .Flush_IFID(ctl[0][0]), .State(st[0]), .Stall_Count(sc0),
        .Timeout_Err(te[0]));

    pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .MC_TIMEOUT(4), .CNT_W(2)) d1 (
        .Clk(Clk), .Reset_n(Reset_n), .Hazard_Req(Hazard_Req), .Branch_Taken(Branch_Taken),
        .MC_Start(MC_Start), .MC_Done(MC_Done), .Clr_Stats(Clr_Stats),
        .Stall_PC(ctl[1][5]), .Stall_IFID(ctl[1][4]), .Hold_IDEX(ctl[1][3]), .Bubble_IDEX(ctl[1][2]),
        .Bubble_EXMEM(ctl[1][1]), .Flush_IFID(ctl[1][0]), .State(st[1]), .Stall_Count(sc1),
        .Timeout_Err(te[1]));

    assign sc[0] = int'(sc0);
    assign sc[1] = int'(sc1);

    int tests = 0, fails = 0;
    int pl [2] = '{1, 3};
    int pf [2] = '{1, 2};
    int pt [2] = '{32, 4};
    int pmax [2] = '{65535, 3};
    // model: mode 0 idle, 1 load stall, 2 mul/div wait, 3 flush; left/waited cycles; stats
    int m_mode [2], m_n [2], m_sc [2], m_te [2];
    int n_mode [2], n_n [2], n_sc [2], n_te [2];

    localparam logic [5:0] MC_O = 6'b111010, LD_O = 6'b110100, FL_O = 6'b000001;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_n[i] = 0; m_sc[i] = 0; m_te[i] = 0;
        end
    endtask

    task automatic step(input logic s, input logic d, input logic h, input logic b, input logic c);
        logic [5:0] e;
        int tmo;
        MC_Start = s; MC_Done = d; Hazard_Req = h; Branch_Taken = b; Clr_Stats = c;
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            e = '0; tmo = 0;
            n_mode[i] = 0; n_n[i] = 0;
            if (m_mode[i] == 0 || (m_mode[i] == 2 && d)) begin
                if (s) begin e = MC_O; n_mode[i] = 2; n_n[i] = 1; end
                else if (h) begin e = LD_O; n_mode[i] = pl[i] > 1 ? 1 : 0; n_n[i] = pl[i] - 1; end
                else if (b) begin e = FL_O; n_mode[i] = pf[i] > 1 ? 3 : 0; n_n[i] = pf[i] - 1; end
            end else if (m_mode[i] == 2) begin
                e = MC_O;
                tmo = m_n[i] >= pt[i];
                n_mode[i] = tmo ? 0 : 2; n_n[i] = m_n[i] + 1;
            end else begin
                e = m_mode[i] == 1 ? LD_O : FL_O;
                n_mode[i] = m_n[i] > 1 ? m_mode[i] : 0; n_n[i] = m_n[i] - 1;
            end
            n_sc[i] = c ? 0 : (e[5] && m_sc[i] < pmax[i]) ? m_sc[i] + 1 : m_sc[i];
            n_te[i] = c ? 0 : (tmo ? 1 : m_te[i]);
            chk($sformatf("d%0d_ctl", i), int'(ctl[i]), int'(e));
            chk($sformatf("d%0d_state", i), int'(st[i]), m_mode[i]);
            chk($sformatf("d%0d_cnt", i), sc[i], m_sc[i]);
            chk($sformatf("d%0d_terr", i), int'(te[i]), m_te[i]);
            chk($sformatf("d%0d_flush_vs_stall", i), int'(ctl[i][4] & ctl[i][0]), 0);
        end
        @(posedge Clk);
        m_mode = n_mode; m_n = n_n; m_sc = n_sc; m_te = n_te;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        Reset_n = 0; MC_Start = 1; MC_Done = 1; Hazard_Req = 1; Branch_Taken = 1; Clr_Stats = 1;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_d%0d_ctl", i), int'(ctl[i]), 0);
            chk($sformatf("rst_d%0d_state", i), int'(st[i]), 0);
        end
        MC_Start = 0; MC_Done = 0; Hazard_Req = 0; Branch_Taken = 0; Clr_Stats = 0;
        #4 Reset_n = 1;
        @(posedge Clk); #1;
        idle(2);
        // single load-use: 1 stall on d0, 3 on d1 (saturating 2-bit count)
        step(0, 0, 1, 0, 0);
        idle(3);
        chk("pin_d0_load_cnt", sc[0], 1);
        chk("pin_d1_load_cnt", sc[1], 3);
        step(0, 0, 0, 0, 1);
        // all sources at once: mul/div wins, requests ignored while waiting
        step(1, 0, 1, 1, 0);
        chk("pin_d0_mc_state", int'(st[0]), 2);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        // hazard beats branch
        step(0, 0, 1, 1, 0);
        idle(3);
        // mul/div done with a branch on the done cycle; d1 times out first
        step(1, 0, 0, 0, 1);
        idle(4);
        step(0, 1, 0, 1, 0);
        chk("pin_d0_after_done_state", int'(st[0]), 0);
        chk("pin_d1_timeout", int'(te[1]), 1);
        idle(2);
        // timeout then clear
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        idle(4);
        chk("pin_d1_to_err", int'(te[1]), 1);
        chk("pin_d1_to_state", int'(st[1]), 0);
        chk("pin_d0_still_wait", int'(st[0]), 2);
        step(0, 1, 0, 0, 1);
        chk("pin_d1_clr_err", int'(te[1]), 0);
        chk("pin_d0_clr_cnt", sc[0], 0);
        // asynchronous reset in the middle of a wait
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        Reset_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mid_rst_d%0d_ctl", i), int'(ctl[i]), 0);
            chk($sformatf("mid_rst_d%0d_state", i), int'(st[i]), 0);
            chk($sformatf("mid_rst_d%0d_cnt", i), sc[i], 0);
        end
        model_reset();
        @(negedge Clk);
        Reset_n = 1;
        @(posedge Clk); #1;
        // saturation: five stall cycles on a 2-bit counter
        step(1, 0, 0, 0, 0);
        idle(4);
        chk("pin_d0_sat_cnt", sc[0], 5);
        chk("pin_d1_sat_cnt", sc[1], 3);
        step(0, 1, 0, 0, 0);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
